// File: rtl/ucaspian_pkg.sv
// Shared types and constants for the uCaspian neuron pipeline.
//   neuron_addr_t    : 8-bit neuron index
//   charge_t         : signed 16-bit accumulated charge
//   weight_t         : signed 8-bit synapse weight
//   dendrite_state_t : dendrite accumulator control states
//   sat_add          : charge + weight, clamped to the charge_t range
package ucaspian_pkg;

  typedef logic [7:0]         neuron_addr_t;
  typedef logic signed [15:0] charge_t;
  typedef logic signed [7:0]  weight_t;

  localparam int unsigned NUM_NEURONS = 256;
  localparam charge_t     CHARGE_MAX  = 16'sh7FFF;
  localparam charge_t     CHARGE_MIN  = 16'sh8000;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_FLUSH,
    ST_DRAIN,
    ST_CLEAR
  } dendrite_state_t;

  // 17-bit sum; bits 16 and 15 disagree exactly when the 16-bit range overflowed.
  function automatic charge_t sat_add(input charge_t a, input weight_t w);
    logic [16:0] s;
    s = {a[15], a} + {{9{w[7]}}, w};
    if (s[16] != s[15]) begin
      return s[16] ? CHARGE_MIN : CHARGE_MAX;
    end
    return charge_t'(s[15:0]);
  endfunction

endpackage

// File: rtl/dp_ram_16x256.sv
// 256 x 16 simple dual-port RAM, one write port and one registered read port.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address, data appears on rd_data after the next edge
//   rd_data : registered read data (read-first on address collision)
module dp_ram_16x256 (
  input  logic        clk,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [7:0]  rd_addr,
  output logic [15:0] rd_data
);

  logic [15:0] mem [256];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ucaspian_lowest_set_256.sv
// Combinational priority encoder: index of the lowest set bit of a 256-bit map.
//   vec : input bit map
//   idx : index of the lowest set bit (0 when vec is empty)
//   any : at least one bit of vec is set
module ucaspian_lowest_set_256
  import ucaspian_pkg::*;
(
  input  logic [NUM_NEURONS-1:0] vec,
  output logic [7:0]             idx,
  output logic                   any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
      if (vec[i] && !any) begin
        idx = i[7:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ucaspian_dendrite.sv
// Per-timestep dendrite charge accumulator.
//   clk, reset            : clock, synchronous active-high reset
//   clear_act / clear_done: discard all charge / clear complete while held
//   next_step             : end-of-timestep pulse, starts the drain
//   step_done             : idle, no drain pending
//   syn_addr/weight/vld/rdy: incoming weighted synapse events
//   neuron_addr/charge/vld/rdy: drained per-neuron charge towards the neuron stage
module ucaspian_dendrite
  import ucaspian_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_act,
  output logic        clear_done,
  input  logic        next_step,
  output logic        step_done,
  input  logic [7:0]  syn_addr,
  input  logic [7:0]  syn_weight,
  input  logic        syn_vld,
  output logic        syn_rdy,
  output logic [7:0]  neuron_addr,
  output logic [15:0] neuron_charge,
  output logic        neuron_vld,
  input  logic        neuron_rdy
);

  dendrite_state_t        state, state_next;
  logic [NUM_NEURONS-1:0] dirty;

  logic         s1_vld;
  neuron_addr_t s1_addr;
  weight_t      s1_weight;
  logic         s2_vld;
  neuron_addr_t s2_addr;
  charge_t      s2_data;

  logic         rd_pending;
  neuron_addr_t pend_addr;
  logic [1:0]   clr_cnt;

  logic         clearing, syn_fire, wr_en, out_fire, drain_idle, drain_issue;
  neuron_addr_t ls_idx, ram_rd_addr;
  logic         ls_any;
  logic [15:0]  ram_rd_data;
  charge_t      old_charge, new_charge;

  assign clearing    = clear_act || (state == ST_CLEAR);
  assign syn_rdy     = !reset && (state == ST_ACCUM) && !next_step && !clear_act;
  assign syn_fire    = syn_vld && syn_rdy;
  assign wr_en       = s1_vld && !clearing;
  assign out_fire    = neuron_vld && neuron_rdy;
  assign drain_idle  = !neuron_vld && !rd_pending;
  assign drain_issue = (state == ST_DRAIN) && !clearing && drain_idle && ls_any;
  assign ram_rd_addr = (state == ST_DRAIN) ? ls_idx : syn_addr;

  dp_ram_16x256 u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (s1_addr),
    .wr_data (new_charge),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  ucaspian_lowest_set_256 u_lowest (
    .vec (dirty),
    .idx (ls_idx),
    .any (ls_any)
  );

  // The RAM read for the event in stage 1 was issued in the same edge as the
  // previous event's write, so a matching stage-2 value must override it.
  always_comb begin
    old_charge = '0;
    if (s2_vld && (s2_addr == s1_addr)) begin
      old_charge = s2_data;
    end else if (dirty[s1_addr]) begin
      old_charge = charge_t'(ram_rd_data);
    end
    new_charge = sat_add(old_charge, s1_weight);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clear_act) begin
      state_next = ST_CLEAR;
    end else begin
      case (state)
        ST_ACCUM: if (next_step) state_next = ST_FLUSH;
        ST_FLUSH: if (!s1_vld) state_next = ST_DRAIN;
        ST_DRAIN: if (!ls_any && drain_idle) state_next = ST_ACCUM;
        ST_CLEAR: if (clr_cnt == 2'd2) state_next = ST_ACCUM;
        default:  state_next = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dirty         <= '0;
      s1_vld        <= 1'b0;
      s1_addr       <= '0;
      s1_weight     <= '0;
      s2_vld        <= 1'b0;
      s2_addr       <= '0;
      s2_data       <= '0;
      rd_pending    <= 1'b0;
      pend_addr     <= '0;
      clr_cnt       <= '0;
      clear_done    <= 1'b0;
      step_done     <= 1'b0;
      neuron_vld    <= 1'b0;
      neuron_addr   <= '0;
      neuron_charge <= '0;
    end else begin
      s1_vld    <= syn_fire;
      s1_addr   <= syn_addr;
      s1_weight <= weight_t'(syn_weight);
      s2_vld    <= wr_en;
      s2_addr   <= s1_addr;
      s2_data   <= new_charge;

      if (clearing) begin
        dirty <= '0;
      end else begin
        if (wr_en) begin
          dirty[s1_addr] <= 1'b1;
        end
        if (out_fire) begin
          dirty[neuron_addr] <= 1'b0;
        end
      end

      if (clearing) begin
        rd_pending <= 1'b0;
        neuron_vld <= 1'b0;
      end else begin
        rd_pending <= drain_issue;
        if (drain_issue) begin
          pend_addr <= ls_idx;
        end
        if (rd_pending) begin
          neuron_vld    <= 1'b1;
          neuron_addr   <= pend_addr;
          neuron_charge <= ram_rd_data;
        end else if (out_fire) begin
          neuron_vld <= 1'b0;
        end
      end

      if (state == ST_CLEAR) begin
        if (clr_cnt != 2'd2) begin
          clr_cnt <= clr_cnt + 2'd1;
        end
      end else begin
        clr_cnt <= '0;
      end
      clear_done <= (state == ST_CLEAR) && clear_act && (clr_cnt != 2'd0);
      step_done  <= (state_next == ST_ACCUM) && !syn_fire;
    end
  end

endmodule

// File: tb/tb_ucaspian_dendrite.sv
module tb_ucaspian_dendrite;

  logic        clk;
  logic        reset;
  logic        clear_act;
  logic        clear_done;
  logic        next_step;
  logic        step_done;
  logic [7:0]  syn_addr;
  logic [7:0]  syn_weight;
  logic        syn_vld;
  logic        syn_rdy;
  logic [7:0]  neuron_addr;
  logic [15:0] neuron_charge;
  logic        neuron_vld;
  logic        neuron_rdy;

  int vectors;
  int miscompares;

  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];

  int m_charge [256];
  bit m_dirty  [256];

  ucaspian_dendrite dut (
    .clk           (clk),
    .reset         (reset),
    .clear_act     (clear_act),
    .clear_done    (clear_done),
    .next_step     (next_step),
    .step_done     (step_done),
    .syn_addr      (syn_addr),
    .syn_weight    (syn_weight),
    .syn_vld       (syn_vld),
    .syn_rdy       (syn_rdy),
    .neuron_addr   (neuron_addr),
    .neuron_charge (neuron_charge),
    .neuron_vld    (neuron_vld),
    .neuron_rdy    (neuron_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake collector: a transfer completes at the next rising edge.
  always @(negedge clk) begin
    if (!reset && !clear_act && neuron_vld && neuron_rdy)
      obs_q.push_back({neuron_addr, neuron_charge});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp_add(input int a, input int w);
    int s;
    s = a + w;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_dirty[i] = 1'b0;
      m_charge[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 256; i++) begin
      if (m_dirty[i]) exp_q.push_back({8'(i), 16'(m_charge[i])});
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic send(input int a, input int w);
    syn_addr = 8'(a);
    syn_weight = 8'(w);
    syn_vld = 1'b1;
    if (!m_dirty[a]) m_charge[a] = 0;
    m_charge[a] = clamp_add(m_charge[a], w);
    m_dirty[a] = 1'b1;
    tick();
  endtask

  task automatic run_step(input bit pulse, output int cycles, output bit timed_out);
    model_step();
    if (pulse) begin
      next_step = 1'b1;
      tick();
      next_step = 1'b0;
    end
    cycles = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 600; i++) begin
      neuron_rdy = 1'b1;
      tick();
      cycles++;
      if (step_done) begin
        timed_out = 1'b0;
        break;
      end
    end
    neuron_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    vectors++; if (syn_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_syn_rdy: got %b expected 0", syn_rdy); end
    vectors++; if (neuron_vld !== 1'b0) begin miscompares++; $display("FAIL reset_neuron_vld: got %b expected 0", neuron_vld); end
    vectors++; if (neuron_addr !== 8'd0) begin miscompares++; $display("FAIL reset_neuron_addr: got %0d expected 0", neuron_addr); end
    vectors++; if (neuron_charge !== 16'd0) begin miscompares++; $display("FAIL reset_neuron_charge: got %0d expected 0", neuron_charge); end
    vectors++; if (step_done !== 1'b0) begin miscompares++; $display("FAIL reset_step_done: got %b expected 0", step_done); end
    vectors++; if (clear_done !== 1'b0) begin miscompares++; $display("FAIL reset_clear_done: got %b expected 0", clear_done); end
    reset = 1'b0;
    model_reset();
    #1;
    vectors++; if (syn_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_release_syn_rdy: got %b expected 1", syn_rdy); end
    tick();
    vectors++; if (step_done !== 1'b1) begin miscompares++; $display("FAIL reset_release_step_done: got %b expected 1", step_done); end
  endtask

  task automatic test_basic();
    int cyc; bit to; logic [23:0] e, o;
    send(5, 10); send(5, 20); send(3, -7);
    syn_vld = 1'b0;
    run_step(1'b1, cyc, to);
    vectors++; if (to) begin miscompares++; $display("FAIL basic_step_done: timed out, expected step_done high"); end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL basic_count: got %0d outputs expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL basic_out: got (%0d,%0d) expected (%0d,%0d)", o[23:16], $signed(o[15:0]), e[23:16], $signed(e[15:0])); end
    end
    exp_q.delete(); obs_q.delete();
    vectors++; if (step_done !== 1'b1) begin miscompares++; $display("FAIL basic_idle: step_done got %b expected 1", step_done); end
  endtask

  task automatic test_saturation();
    int cyc; bit to; logic [23:0] e, o;
    for (int pass = 0; pass < 3; pass++) begin
      if (pass == 0) for (int i = 0; i < 300; i++) send(9, 127);
      else if (pass == 1) for (int i = 0; i < 300; i++) send(9, -128);
      else begin
        for (int i = 0; i < 300; i++) send(20, 127);
        send(20, 1); send(20, -1);
      end
      syn_vld = 1'b0;
      run_step(1'b1, cyc, to);
      vectors++; if (to) begin miscompares++; $display("FAIL sat_step_done: pass %0d timed out", pass); end
      vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL sat_count: pass %0d got %0d outputs expected %0d", pass, obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        vectors++; if (o !== e) begin miscompares++; $display("FAIL sat_out: pass %0d got (%0d,%0d) expected (%0d,%0d)", pass, o[23:16], $signed(o[15:0]), e[23:16], $signed(e[15:0])); end
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_backpressure();
    bit held, to; logic [24:0] held_val; logic [23:0] e, o;
    send(40, 11); send(2, -3); send(200, 99); send(77, -50);
    syn_vld = 1'b0;
    model_step();
    next_step = 1'b1;
    tick();
    held = 1'b0; held_val = '0; to = 1'b1;
    for (int i = 0; i < 600; i++) begin
      neuron_rdy = 1'($urandom_range(0, 1));
      next_step = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (held) begin
        vectors++;
        if ({neuron_vld, neuron_addr, neuron_charge} !== held_val) begin
          miscompares++;
          $display("FAIL bp_hold: got vld=%b (%0d,%0d) expected vld=%b (%0d,%0d)", neuron_vld, neuron_addr, $signed(neuron_charge), held_val[24], held_val[23:16], $signed(held_val[15:0]));
        end
      end
      held = neuron_vld && !neuron_rdy;
      held_val = {neuron_vld, neuron_addr, neuron_charge};
      @(posedge clk); #1;
      if (step_done) begin to = 1'b0; break; end
    end
    next_step = 1'b0; neuron_rdy = 1'b0;
    vectors++; if (to) begin miscompares++; $display("FAIL bp_step_done: timed out, expected step_done high"); end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL bp_count: got %0d handshakes expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL bp_out: got (%0d,%0d) expected (%0d,%0d)", o[23:16], $signed(o[15:0]), e[23:16], $signed(e[15:0])); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_clear_mid_drain();
    int cyc; bit to; logic [23:0] e, o;
    send(10, 1); send(11, 2); send(12, 3);
    syn_vld = 1'b0;
    model_step();
    next_step = 1'b1;
    tick();
    next_step = 1'b0;
    neuron_rdy = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs_q.size() >= 1) begin to = 1'b0; break; end
    end
    neuron_rdy = 1'b0;
    vectors++; if (to) begin miscompares++; $display("FAIL clr_first_out: timed out waiting for first handshake"); end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL clr_first_val: got (%0d,%0d) expected (%0d,%0d)", o[23:16], $signed(o[15:0]), e[23:16], $signed(e[15:0])); end
    end
    to = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (neuron_vld) begin to = 1'b0; break; end
      tick();
    end
    vectors++; if (to) begin miscompares++; $display("FAIL clr_second_vld: timed out waiting for second neuron_vld"); end
    clear_act = 1'b1;
    tick();
    vectors++; if (neuron_vld !== 1'b0) begin miscompares++; $display("FAIL clr_vld_drop: got %b expected 0", neuron_vld); end
    tick(); tick();
    vectors++; if (clear_done !== 1'b1) begin miscompares++; $display("FAIL clr_done_high: got %b expected 1", clear_done); end
    vectors++; if (step_done !== 1'b0) begin miscompares++; $display("FAIL clr_step_done_low: got %b expected 0", step_done); end
    clear_act = 1'b0;
    tick();
    vectors++; if (clear_done !== 1'b0) begin miscompares++; $display("FAIL clr_done_release: got %b expected 0", clear_done); end
    vectors++; if (step_done !== 1'b1) begin miscompares++; $display("FAIL clr_release_idle: step_done got %b expected 1", step_done); end
    exp_q.delete();
    run_step(1'b1, cyc, to);
    vectors++; if (to || cyc > 3) begin miscompares++; $display("FAIL clr_empty_step: step_done after %0d cycles (timeout=%b) expected <= 3", cyc, to); end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL clr_no_output: got %0d outputs expected 0", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_edges();
    int cyc; bit to; logic [23:0] e, o;
    send(0, 1); send(255, 4); send(255, -4);
    syn_addr = 8'd100; syn_weight = 8'd50; syn_vld = 1'b1;
    next_step = 1'b1;
    #1;
    vectors++; if (syn_rdy !== 1'b0) begin miscompares++; $display("FAIL edge_rdy_on_step: got %b expected 0", syn_rdy); end
    tick();
    syn_vld = 1'b0; next_step = 1'b0;
    run_step(1'b0, cyc, to);
    vectors++; if (to) begin miscompares++; $display("FAIL edge_step_done: timed out, expected step_done high"); end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL edge_count: got %0d outputs expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL edge_out: got (%0d,%0d) expected (%0d,%0d)", o[23:16], $signed(o[15:0]), e[23:16], $signed(e[15:0])); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int cyc; bit to;
    send(7, 50);
    syn_vld = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    run_step(1'b1, cyc, to);
    vectors++; if (to || cyc > 3) begin miscompares++; $display("FAIL rstmid_step_done: after %0d cycles (timeout=%b) expected <= 3", cyc, to); end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL rstmid_no_output: got %0d outputs expected 0", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    clear_act = 1'b0;
    next_step = 1'b0;
    syn_addr = '0;
    syn_weight = '0;
    syn_vld = 1'b0;
    neuron_rdy = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_clear_mid_drain();
    test_edges();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ucaspian_dendrite.md
# ucaspian_dendrite

Per-timestep charge accumulator feeding the neuron stage. It accepts weighted synapse events and sums them per target neuron into a 256-entry charge buffer. On `next_step` it drains every touched entry, in ascending address order, to the neuron's dendrite->neuron port through a valid/ready handshake. It sits between synapse/axon fan-out and `ucaspian_neuron`.

## Interface
Parameters: none; widths come from the shared package.

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `clear_act`  in  1  level; discard all accumulated charge
- `clear_done`  out  1  high while clear is complete and `clear_act` is still high
- `next_step`  in  1  single-cycle pulse; end of timestep, start drain
- `step_done`  out  1  level; block idle, no drain pending
- `syn_addr`  in  8  target neuron of synapse event
- `syn_weight`  in  8  signed weight to add
- `syn_vld` / `syn_rdy`  in / out  1  synapse event handshake
- `neuron_addr`  out  8  to neuron
- `neuron_charge`  out  16  signed accumulated charge
- `neuron_vld` / `neuron_rdy`  out / in  1  dendrite->neuron handshake

## Operation
States:
- **ACCUM**
  - `syn_rdy = (state==ACCUM) && !next_step && !clear_act`. Combinational.
  - Each handshake performs read-modify-write on the charge RAM. An entry whose dirty bit is clear reads as 0.
  - New value = clamp(old + sign-extended weight) to [-32768, 32767], computed in 17 bits.
  - The dirty bit is set on write.
  - One event is accepted per cycle.
  - Back-to-back events to the same address must accumulate exactly. The stage-2 result is forwarded; no stall.
- **FLUSH**
  - Entered on `next_step` in ACCUM.
  - Waits until the RMW pipeline is empty (at most 2 cycles).
- **DRAIN**
  - A lowest-set-bit search over the 256-bit dirty map selects the next address.
  - The RAM read completes before presentation. `neuron_vld` is then raised with addr/charge.
  - `neuron_vld`, `neuron_addr` and `neuron_charge` hold stable until `neuron_rdy`.
  - On handshake the dirty bit for that address is cleared.
  - Zero-valued dirty entries are still sent.
  - When the dirty map is empty and there is no output outstanding, the block returns to ACCUM.
- **CLEAR**
  - Entered from any state on `clear_act`.
  - Zeroes the dirty map in one cycle and drops `neuron_vld` immediately, with no handshake required.
  - Drains the pipeline; in-flight writes are discarded.
  - `clear_done` is raised 2 cycles after entry and held until `clear_act` falls, then the block returns to ACCUM.
  - RAM contents are not scrubbed; dirty bits gate them.

`step_done`:
- High in ACCUM with the pipeline empty and no `next_step` this cycle.
- Low from the `next_step` cycle through the end of DRAIN.
- Low in CLEAR.

Boundary conditions:
- `next_step` during FLUSH/DRAIN/CLEAR: ignored; must not corrupt state or duplicate outputs.
- `next_step` with zero dirty entries: FLUSH -> ACCUM, no output. `step_done` returns high within 3 cycles.
- Saturation is sticky per accumulation:
  - 32767 + 1 stays 32767.
  - A subsequent -1 gives 32766.
- Address 255 and address 0 need no special case. The drain order is strictly ascending.

## Timing
Reset values:
- `syn_rdy` 0; rises the first cycle after `reset` falls.
- `neuron_vld` 0, `neuron_addr` 0, `neuron_charge` 0.
- `step_done` 0; high 1 cycle after reset is released.
- `clear_done` 0.
- Dirty map all 0; state ACCUM.

Latencies:
- Event accepted at edge E0: written by E2. Visible to another event accepted at E1 or E2 via forwarding.
- `next_step` at edge N with an empty pipeline: first `neuron_vld` no later than N+4.
- After a handshake: next `neuron_vld` no later than 3 cycles later. Throughput is at least 1 entry / 3 cycles with `neuron_rdy` held high.
- `neuron_rdy` low stalls indefinitely with no data change.

Outputs:
- All outputs are registered except `syn_rdy`.
- `reset` mid-operation discards everything and returns to the reset values above.

## Structure
- `ucaspian_pkg` holds:
  - `neuron_addr_t` (logic [7:0]), `charge_t` (logic signed [15:0]), `weight_t` (logic signed [7:0])
  - `NUM_NEURONS` = 256, `CHARGE_MAX` = 32767, `CHARGE_MIN` = -32768
  - State enum `dendrite_state_t`
- Charge storage: existing `dp_ram_16x256` (1-cycle registered read).
- Sub-module: `ucaspian_lowest_set_256`, combinational. 256-bit in, 8-bit index + `any` out.

## Test plan
- **Basic accumulate and drain:** events (5,+10), (5,+20), (3,-7), then `next_step`. Neuron sees (3,-7) then (5,30); `step_done` high afterward.
- **Forwarding and saturation:** 300 back-to-back events (9,+127), `next_step`. Single output (9,32767). Repeat with -128: (9,-32768).
- **Backpressure:** drain 4 dirty entries with `neuron_rdy` toggled randomly. Each value is held stable while `neuron_vld` is high and `neuron_rdy` is low; exactly 4 handshakes, ascending order.
- **Clear mid-drain:** `clear_act` after the 1st of 3 outputs. `neuron_vld` is low the next cycle; `clear_done` is high within 2 cycles. After release, `next_step` produces no output.
- **Edge addresses and zero sum:** events (0,+1), (255,+4), (255,-4), `next_step`. Outputs (0,1) then (255,0). `next_step` with `syn_vld` asserted in the same cycle: `syn_rdy` is low and the event is not counted.
- **Reset mid-accumulate:** accumulate (7,+50), assert `reset` for 1 cycle, then `next_step`. No output.
